// File: rtl/audio_matrix_pkg.sv
// Shared types and width/saturation helpers for the audio crosspoint mixer.
// Optional saturation build: define AUDIO_MATRIX_SAT_EN.
package audio_matrix_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Gains are Q2.(gain_bits-2), so unity sits two bits below the top.
    function automatic int GAIN_UNITY(input int gain_bits);
        return 1 << (gain_bits - 2);
    endfunction

    function automatic int acc_width(input int bitsize, input int gain_bits, input int n_in);
        return bitsize + gain_bits + $clog2(n_in);
    endfunction

    function automatic int addr_width(input int n_in, input int n_out);
        return (n_in * n_out > 1) ? $clog2(n_in * n_out) : 1;
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/audio_matrix_mac.sv
// Two-stage multiply/accumulate datapath: registered product, then accumulate with
// scale and narrow on the last term of each output (clamped when AUDIO_MATRIX_SAT_EN).
module audio_matrix_mac
    import audio_matrix_pkg::*;
#(
    parameter int BITSIZE   = 16,
    parameter int GAIN_BITS = 8,
    parameter int N_IN      = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        vld,
    input  logic                        last,
    input  logic signed [BITSIZE-1:0]   sample,
    input  logic signed [GAIN_BITS-1:0] gain,
    output logic [BITSIZE-1:0]          result,
    output logic                        result_valid
);

    localparam int PW    = BITSIZE + GAIN_BITS;
    localparam int ACC_W = acc_width(BITSIZE, GAIN_BITS, N_IN);
    localparam int SHIFT = GAIN_BITS - 2;

    logic signed [PW-1:0]    prod_r;
    logic                    prod_vld_r;
    logic                    prod_last_r;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] scaled;
    logic [BITSIZE-1:0]      narrowed;
`ifdef AUDIO_MATRIX_SAT_EN
    logic signed [63:0]      clamped;
`endif

    always_comb begin
        sum    = acc + ACC_W'(prod_r);
        // Arithmetic shift floors toward minus infinity.
        scaled = sum >>> SHIFT;
`ifdef AUDIO_MATRIX_SAT_EN
        clamped  = sat_clamp(64'(scaled), BITSIZE);
        narrowed = BITSIZE'(clamped);
`else
        narrowed = BITSIZE'(scaled);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r       <= '0;
            prod_vld_r   <= 1'b0;
            prod_last_r  <= 1'b0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            prod_r       <= PW'(sample) * PW'(gain);
            prod_vld_r   <= vld && !clr;
            prod_last_r  <= last;
            result_valid <= 1'b0;
            if (clr) begin
                acc <= '0;
            end else if (prod_vld_r) begin
                if (prod_last_r) begin
                    acc          <= '0;
                    result       <= narrowed;
                    result_valid <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/audio_matrix_mixer.sv
// N_IN x N_OUT weighted crosspoint mixer with shadow/active gain banks and one shared MAC.
// Saturating output narrowing is enabled by defining AUDIO_MATRIX_SAT_EN.
module audio_matrix_mixer
    import audio_matrix_pkg::*;
#(
    parameter int BITSIZE   = 16,
    parameter int N_IN      = 11,
    parameter int N_OUT     = 12,
    parameter int GAIN_BITS = 8,
    localparam int ADDR_W   = addr_width(N_IN, N_OUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_stb,
    input  logic [N_IN*BITSIZE-1:0]  in_bus,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [GAIN_BITS-1:0]     wr_data,
    input  logic                     commit,
    input  logic                     ovr_clr,
    output logic [N_OUT*BITSIZE-1:0] out_bus,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     commit_pending
);

    localparam int N  = N_IN * N_OUT;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                      state;
    logic [IW-1:0]               i_cnt;
    logic [ADDR_W-1:0]           idx;
    logic [OW-1:0]               res_idx;
    logic                        drain_cnt;
    logic signed [GAIN_BITS-1:0] shadow [N];
    logic signed [GAIN_BITS-1:0] active [N];
    logic signed [BITSIZE-1:0]   in_reg [N_IN];
    logic [BITSIZE-1:0]          res_reg [N_OUT];
    logic [BITSIZE-1:0]          res_next [N_OUT];
    logic [BITSIZE-1:0]          mac_result;
    logic                        mac_result_valid;
    logic                        wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < N);
    assign busy  = (state != IDLE);

    // The last output's result lands in the same cycle DONE is entered, so bypass it.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) res_next[k] = res_reg[k];
        if (mac_result_valid) res_next[res_idx] = mac_result;
    end

    audio_matrix_mac #(
        .BITSIZE   (BITSIZE),
        .GAIN_BITS (GAIN_BITS),
        .N_IN      (N_IN)
    ) u_mac (
        .clk          (clk),
        .rst          (rst),
        .clr          (state == LOAD),
        .vld          (state == RUN),
        .last         (i_cnt == IW'(N_IN - 1)),
        .sample       (in_reg[i_cnt]),
        .gain         (active[idx]),
        .result       (mac_result),
        .result_valid (mac_result_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            i_cnt          <= '0;
            idx            <= '0;
            res_idx        <= '0;
            drain_cnt      <= 1'b0;
            out_bus        <= '0;
            out_valid      <= 1'b0;
            overrun        <= 1'b0;
            commit_pending <= 1'b0;
            for (int k = 0; k < N; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            for (int k = 0; k < N_IN; k++) in_reg[k] <= '0;
            for (int k = 0; k < N_OUT; k++) res_reg[k] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (wr_ok) shadow[wr_addr] <= wr_data;

            // A commit arriving during LOAD must survive the clear below.
            if (commit) commit_pending <= 1'b1;
            else if (state == LOAD) commit_pending <= 1'b0;

            if (sample_stb && busy) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;

            for (int k = 0; k < N_OUT; k++) res_reg[k] <= res_next[k];
            if (mac_result_valid) res_idx <= res_idx + 1'b1;

            case (state)
                IDLE: begin
                    if (sample_stb) state <= LOAD;
                end
                LOAD: begin
                    for (int k = 0; k < N_IN; k++) in_reg[k] <= in_bus[k*BITSIZE +: BITSIZE];
                    if (commit_pending) begin
                        for (int k = 0; k < N; k++) active[k] <= shadow[k];
                    end
                    i_cnt   <= '0;
                    idx     <= '0;
                    res_idx <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (i_cnt == IW'(N_IN - 1)) i_cnt <= '0;
                    else i_cnt <= i_cnt + 1'b1;
                    if (idx == ADDR_W'(N - 1)) begin
                        idx       <= '0;
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        for (int k = 0; k < N_OUT; k++) out_bus[k*BITSIZE +: BITSIZE] <= res_next[k];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_matrix_mixer.sv
// Directed bench for audio_matrix_mixer in a 2x2 configuration with hand-computed results.
// Expected overflow behaviour follows AUDIO_MATRIX_SAT_EN.
module tb_audio_matrix_mixer;
    import audio_matrix_pkg::*;

    logic        clk;
    logic        rst;
    logic        sample_stb;
    logic [31:0] in_bus;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        commit;
    logic        ovr_clr;
    logic [31:0] out_bus;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic        commit_pending;

    int checks = 0;
    int passed = 0;

    audio_matrix_mixer #(
        .BITSIZE   (16),
        .N_IN      (2),
        .N_OUT     (2),
        .GAIN_BITS (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_stb     (sample_stb),
        .in_bus         (in_bus),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .ovr_clr        (ovr_clr),
        .out_bus        (out_bus),
        .out_valid      (out_valid),
        .busy           (busy),
        .overrun        (overrun),
        .commit_pending (commit_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_gain(input int addr, input int val, input logic with_commit);
        wr_en   = 1'b1;
        wr_addr = 2'(addr);
        wr_data = 8'(val);
        commit  = with_commit;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    // Pulse the strobe, wait (bounded) for out_valid, then step into IDLE.
    task automatic run_frame(input int a, input int b, output logic [15:0] o0,
                             output logic [15:0] o1, output int lat);
        in_bus     = {16'(b), 16'(a)};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        o0 = out_bus[15:0];
        o1 = out_bus[31:16];
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_stb = 1'b0; in_bus = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; commit = 1'b0; ovr_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (out_bus !== 32'h0) $display("FAIL reset_out_bus: got %h expected 0", out_bus); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        checks++; if (commit_pending !== 1'b0) $display("FAIL reset_commit_pending: got %b expected 0", commit_pending); else passed++;
    endtask

    task automatic test_unity();
        logic [15:0] o0, o1;
        int lat;
        write_gain(0, GAIN_UNITY(8), 1'b0);
        write_gain(3, 64, 1'b0);
        do_commit();
        checks++; if (commit_pending !== 1'b1) $display("FAIL unity_pending_set: got %b expected 1", commit_pending); else passed++;
        run_frame(1000, -2000, o0, o1, lat);
        checks++; if (lat !== 8) $display("FAIL unity_latency: got %0d expected 8", lat); else passed++;
        checks++; if (o0 !== 16'(1000)) $display("FAIL unity_out0: got %0d expected 1000", $signed(o0)); else passed++;
        checks++; if (o1 !== 16'(-2000)) $display("FAIL unity_out1: got %0d expected -2000", $signed(o1)); else passed++;
        checks++; if (commit_pending !== 1'b0) $display("FAIL unity_pending_clear: got %b expected 0", commit_pending); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL unity_valid_pulse: got %b expected 0", out_valid); else passed++;
        repeat (5) tick();
        checks++; if (out_bus !== {16'(-2000), 16'(1000)}) $display("FAIL unity_hold: got %h expected %h", out_bus, {16'(-2000), 16'(1000)}); else passed++;
    endtask

    task automatic test_overflow();
        logic [15:0] o0, o1, exp0;
        int lat;
`ifdef AUDIO_MATRIX_SAT_EN
        exp0 = 16'(32767);
`else
        exp0 = 16'(-5536);
`endif
        write_gain(1, 64, 1'b0);
        do_commit();
        run_frame(30000, 30000, o0, o1, lat);
        checks++; if (lat !== 8) $display("FAIL overflow_latency: got %0d expected 8", lat); else passed++;
        checks++; if (o0 !== exp0) $display("FAIL overflow_out0: got %0d expected %0d", $signed(o0), $signed(exp0)); else passed++;
        checks++; if (o1 !== 16'(30000)) $display("FAIL overflow_out1: got %0d expected 30000", $signed(o1)); else passed++;
    endtask

    task automatic test_gain_math();
        logic [15:0] o0, o1;
        int lat;
        // gain1 -> 0 is written in the same cycle as the commit; 64 would give -150.
        write_gain(0, -128, 1'b0);
        write_gain(1, 0, 1'b1);
        run_frame(100, 50, o0, o1, lat);
        checks++; if (o0 !== 16'(-200)) $display("FAIL neg_gain_out0: got %0d expected -200", $signed(o0)); else passed++;
        checks++; if (o1 !== 16'(50)) $display("FAIL neg_gain_out1: got %0d expected 50", $signed(o1)); else passed++;
        write_gain(0, 32, 1'b1);
        run_frame(-3, 7, o0, o1, lat);
        checks++; if (o0 !== 16'(-2)) $display("FAIL floor_out0: got %0d expected -2", $signed(o0)); else passed++;
        checks++; if (o1 !== 16'(7)) $display("FAIL floor_out1: got %0d expected 7", $signed(o1)); else passed++;
    endtask

    task automatic test_commit_timing();
        logic [15:0] o0, o1;
        int lat;
        write_gain(0, 64, 1'b0);
        run_frame(-3, 7, o0, o1, lat);
        checks++; if (o0 !== 16'(-2)) $display("FAIL no_commit_out0: got %0d expected -2", $signed(o0)); else passed++;
        checks++; if (commit_pending !== 1'b0) $display("FAIL no_commit_pending: got %b expected 0", commit_pending); else passed++;

        in_bus     = {16'(7), 16'(-3)};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
        tick();
        do_commit();
        lat = 4;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 8) $display("FAIL run_commit_latency: got %0d expected 8", lat); else passed++;
        checks++; if (out_bus[15:0] !== 16'(-2)) $display("FAIL run_commit_old_gain: got %0d expected -2", $signed(out_bus[15:0])); else passed++;
        tick();
        checks++; if (commit_pending !== 1'b1) $display("FAIL run_commit_pending: got %b expected 1", commit_pending); else passed++;

        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        checks++; if (commit_pending !== 1'b1) $display("FAIL load_pending_high: got %b expected 1", commit_pending); else passed++;
        tick();
        checks++; if (commit_pending !== 1'b0) $display("FAIL load_pending_drop: got %b expected 0", commit_pending); else passed++;
        lat = 2;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (out_bus[15:0] !== 16'(-3)) $display("FAIL run_commit_new_gain: got %0d expected -3", $signed(out_bus[15:0])); else passed++;
        tick();
    endtask

    task automatic test_overrun();
        logic [15:0] o0, o1;
        int lat;
        int pulses;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL busy_in_load: got %b expected 1", busy); else passed++;
        tick();
        tick();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else passed++;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) $display("FAIL overrun_pulses: got %0d expected 1", pulses); else passed++;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", overrun); else passed++;

        run_frame(1, 2, o0, o1, lat);
        run_frame(1, 2, o0, o1, lat);
        checks++; if (lat !== 8) $display("FAIL back_to_back_latency: got %0d expected 8", lat); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL back_to_back_overrun: got %b expected 0", overrun); else passed++;

        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        // Strobe during DONE collides with a clear: the set must win.
        sample_stb = 1'b1;
        ovr_clr    = 1'b1;
        tick();
        sample_stb = 1'b0;
        ovr_clr    = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL done_stb_overrun: got %b expected 1", overrun); else passed++;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL done_stb_pulses: got %0d expected 0", pulses); else passed++;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] o0, o1;
        int lat;
        int pulses;
        in_bus     = {16'(1000), 16'(1000)};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else passed++;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL mid_reset_pulses: got %0d expected 0", pulses); else passed++;
        run_frame(1000, 1000, o0, o1, lat);
        checks++; if (lat !== 8) $display("FAIL mid_reset_latency: got %0d expected 8", lat); else passed++;
        checks++; if ({o1, o0} !== 32'h0) $display("FAIL mid_reset_gains_zero: got %h expected 0", {o1, o0}); else passed++;
    endtask

    initial begin
        test_reset();
        test_unity();
        test_overflow();
        test_gain_math();
        test_commit_timing();
        test_overrun();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/audio_matrix_mixer.md
# audio_matrix_mixer

Parametrised N_IN × N_OUT audio crosspoint mixer. It replaces the fixed one-of-N select matrix between the synth voices, effects and the I2S ports: each output is a weighted sum of all inputs, using signed per-crosspoint gains. Gains are written by the RocketCPU into a shadow bank and applied atomically at the next frame start. A single time-multiplexed MAC runs on the OSC domain and processes one frame per DACLRC-derived sample strobe.

## Interface
- BITSIZE, 16: sample width, signed two's complement.
- N_IN, 11: number of inputs.
- N_OUT, 12: number of outputs.
- GAIN_BITS, 8: signed gain in Q2.(GAIN_BITS-2) format; unity = 2^(GAIN_BITS-2), which is 64 at the default.
- clk  in  1  system clock (OSC, 49.152 MHz).
- rst  in  1  synchronous, active-high reset.
- sample_stb  in  1  one-cycle pulse per audio frame, already synchronised to clk.
- in_bus  in  N_IN*BITSIZE  input samples; input i occupies [i*BITSIZE +: BITSIZE].
- wr_en  in  1  shadow gain write strobe.
- wr_addr  in  $clog2(N_IN*N_OUT)  crosspoint index = out*N_IN + in.
- wr_data  in  GAIN_BITS  signed gain value.
- commit  in  1  one-cycle pulse requesting shadow→active copy.
- ovr_clr  in  1  clears the overrun flag.
- out_bus  out  N_OUT*BITSIZE  mixed outputs, same packing as in_bus; reset value 0.
- out_valid  out  1  one-cycle pulse when out_bus updates; reset value 0.
- busy  out  1  high while a frame is in progress; reset value 0.
- overrun  out  1  sticky flag; reset value 0.
- commit_pending  out  1  high from commit until the bank is applied; reset value 0.

## Operation
- The FSM has five states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE → LOAD on sample_stb.
- LOAD: latch in_bus into in_reg. If commit_pending, copy the whole shadow bank into the active bank and clear commit_pending. Zero the accumulator and set the o/i counters to 0.
- RUN lasts exactly N_IN*N_OUT cycles, one MAC per cycle, with i as the inner index and o as the outer.
  - Per cycle: product = in_reg[i] * active[o*N_IN+i], full-precision signed, BITSIZE+GAIN_BITS bits.
  - Accumulator width is BITSIZE+GAIN_BITS+$clog2(N_IN) bits, so it never overflows.
  - After the last input of output o: result[o] = acc >>> (GAIN_BITS-2), an arithmetic (floor) shift, then narrowed to BITSIZE. The accumulator then restarts at 0.
- DRAIN lasts 2 cycles to flush the product and accumulate pipeline.
- DONE: copy the result registers to out_bus, pulse out_valid, then go to IDLE.
- Writes:
  - A write with wr_en and wr_addr < N_IN*N_OUT updates that shadow entry in any state.
  - A write with wr_addr ≥ N_IN*N_OUT is ignored.
- Commit:
  - commit sets commit_pending in any state.
  - A write and a commit in the same cycle: the write is included in that commit.
  - A commit or write during the LOAD cycle is not applied this frame; it is applied at the next LOAD.
- Overrun:
  - sample_stb while busy is ignored and sets overrun.
  - ovr_clr clears overrun. If ovr_clr and a set happen in the same cycle, set wins.
- Reset values:
  - Active and shadow gains reset to 0.
  - All outputs, counters and the accumulator reset to 0; the FSM resets to IDLE.
  - Reset mid-frame abandons the frame without any out_valid pulse.

## Timing
- Take sample_stb high in IDLE as cycle 0.
- Cycle 1 is LOAD. Cycles 2..N+1 are RUN, where N = N_IN*N_OUT. Cycles N+2 and N+3 are DRAIN. Cycle N+4 is DONE.
- out_valid is high in cycle N+4, when out_bus is already new. At the defaults this is 136 cycles.
- busy is high in cycles 1..N+4. A sample_stb in cycle N+5 or later starts a new frame.
- The worst case must fit the frame budget: N+4 ≤ 1024 cycles at 48 kHz.
- out_bus holds its value between DONE pulses.

## Configuration
- AUDIO_MATRIX_SAT_EN defined: each result is clamped to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1] before narrowing.
- AUDIO_MATRIX_SAT_EN undefined: results are truncated to the low BITSIZE bits, so overflow wraps.

## Structure
- audio_matrix_pkg holds:
  - the state enum;
  - GAIN_UNITY(GAIN_BITS);
  - the accumulator and address width functions;
  - the saturation function.
- One sub-module, audio_matrix_mac, contains the registered multiply, accumulate, shift and saturate/narrow datapath. It takes a clear and a last strobe and emits result plus result_valid.
- The FSM, counters, gain banks and flags live in the top level.

## Test plan
- Bench configuration N_IN=2, N_OUT=2, GAIN_BITS=8, BITSIZE=16; reset → all outputs 0. Write gains to addresses 0 and 3 with value 64, commit, stb with in = {1000, -2000} → out_valid exactly 8 cycles after stb; out = {1000, -2000}.
- Gains at addresses 0 and 1 are 64, in = {30000, 30000}:
  - with SAT_EN → out0 = 32767;
  - without SAT_EN → out0 = 60000-65536 = -5536.
- Gain -128 (-2.0) at address 0, in0 = 100 → out0 = -200. Gain 32 (0.5) at address 0, in0 = -3 → out0 = -2 (floor).
- Write with no commit, then stb → old gains used, commit_pending stays 0. Commit during RUN → current frame unchanged, next frame uses the new gains, commit_pending drops in that next frame's LOAD.
- Second stb 3 cycles after the first → no extra out_valid, overrun = 1. ovr_clr → overrun = 0.
- Assert rst in RUN → no out_valid, busy = 0 next cycle, gains read back as 0 on the following frame (out = 0).
